// File: rtl/lookup_cfg_sequencer.sv
// lookup_cfg_sequencer
//   Arbitrates between two requesters that want to program a TCAM entry and sequences the write:
//   TCAM key/mask write, wait for the TCAM busy phase (bounded by TMO), action RAM write, then a
//   completion pulse. Round-robin arbitration, requester 0 preferred out of reset.
//
// Ports
//   axis_clk, areset              clock, asynchronous active-high reset
//   reqN_valid/ready              request handshake (ready is a one-cycle accept pulse)
//   reqN_addr/key/mask/action     entry payload, sampled in the arbitration cycle
//   cam_busy                      TCAM write in progress
//   lookup_din*/lookup_din_en     TCAM write port
//   action_data_in/addr/en        action RAM write port
//   cfg_done/cfg_done_id          completion pulse and the requester served
//   cfg_err                       sticky busy-phase timeout flag
module lookup_cfg_sequencer #(
  parameter int unsigned KEY_W  = 1024,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ACT_W  = 25,
  parameter int unsigned TMO    = 15
) (
  input  logic              axis_clk,
  input  logic              areset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [KEY_W-1:0]  req0_key,
  input  logic [KEY_W-1:0]  req0_mask,
  input  logic [ACT_W-1:0]  req0_action,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [KEY_W-1:0]  req1_key,
  input  logic [KEY_W-1:0]  req1_mask,
  input  logic [ACT_W-1:0]  req1_action,
  input  logic              cam_busy,
  output logic [KEY_W-1:0]  lookup_din,
  output logic [KEY_W-1:0]  lookup_din_mask,
  output logic [ADDR_W-1:0] lookup_din_addr,
  output logic              lookup_din_en,
  output logic [ACT_W-1:0]  action_data_in,
  output logic [ADDR_W-1:0] action_addr,
  output logic              action_en,
  output logic              cfg_done,
  output logic              cfg_done_id,
  output logic              cfg_err
);

  localparam int unsigned CntW = (TMO < 1) ? 1 : $clog2(TMO + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StCamWr,
    StCamWait,
    StActWr,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ACT_W-1:0]  act_q, act_d;
  logic              win_q, win_d;
  logic              last_q, last_d;   // requester served last; reset to 1 so 0 wins first tie
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              seen_q, seen_d;   // cam_busy observed high during the wait phase
  logic              err_q, err_d;

  logic grant_vld;
  logic grant_id;
  logic timeout;

  // Grant is re-evaluated from the live valids in the arbitration cycle.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  // cnt_q counts wait cycles already spent; the TMO-th wait cycle is the last one.
  assign timeout = (cnt_q >= CntW'(TMO - 1));

  // State and datapath registers.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      key_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      act_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    act_d   = act_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) state_d = StArb;
      end
      StArb: begin
        if (grant_vld) begin
          win_d   = grant_id;
          key_d   = grant_id ? req1_key    : req0_key;
          mask_d  = grant_id ? req1_mask   : req0_mask;
          addr_d  = grant_id ? req1_addr   : req0_addr;
          act_d   = grant_id ? req1_action : req0_action;
          state_d = StCamWr;
        end else begin
          state_d = StIdle;
        end
      end
      StCamWr: begin
        if (!cam_busy) begin
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = StCamWait;
        end
      end
      StCamWait: begin
        if (cam_busy) seen_d = 1'b1;
        if (seen_q && !cam_busy) begin
          state_d = StActWr;
        end else if (timeout) begin
          // Busy still high at the deadline means the TCAM never finished.
          if (cam_busy) err_d = 1'b1;
          state_d = StActWr;
        end else if (cnt_q != CntW'(TMO)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StActWr: begin
        state_d = StDone;
      end
      StDone: begin
        last_d  = win_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: strobes decoded from state, data held in the latched registers.
  always_comb begin
    req0_ready      = (state_q == StArb) && grant_vld && !grant_id;
    req1_ready      = (state_q == StArb) && grant_vld && grant_id;
    lookup_din_en   = (state_q == StCamWr) && !cam_busy;
    action_en       = (state_q == StActWr);
    cfg_done        = (state_q == StDone);
    cfg_done_id     = (state_q == StDone) && win_q;
    cfg_err         = err_q;
    lookup_din      = key_q;
    lookup_din_mask = mask_q;
    lookup_din_addr = addr_q;
    action_addr     = addr_q;
    action_data_in  = act_q;
  end

endmodule

// File: tb/tb_lookup_cfg_sequencer.sv
// Self-checking bench for lookup_cfg_sequencer: directed scenarios plus randomized transactions
// checked against a transaction-level model (round-robin winner, write timing, sticky error).
module tb_lookup_cfg_sequencer;

  localparam int unsigned KEY_W  = 1024;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned ACT_W  = 25;
  localparam int unsigned TMO    = 15;

  logic axis_clk = 1'b0;
  logic areset   = 1'b1;
  logic req0_valid = 1'b0;
  logic req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [KEY_W-1:0]  key_r  [2];
  logic [KEY_W-1:0]  mask_r [2];
  logic [ADDR_W-1:0] addr_r [2];
  logic [ACT_W-1:0]  act_r  [2];
  logic cam_busy = 1'b0;
  logic [KEY_W-1:0]  lookup_din, lookup_din_mask;
  logic [ADDR_W-1:0] lookup_din_addr, action_addr;
  logic [ACT_W-1:0]  action_data_in;
  logic lookup_din_en, action_en, cfg_done, cfg_done_id, cfg_err;

  always #5 axis_clk = ~axis_clk;

  lookup_cfg_sequencer #(
    .KEY_W  (KEY_W),
    .ADDR_W (ADDR_W),
    .ACT_W  (ACT_W),
    .TMO    (TMO)
  ) dut (
    .axis_clk        (axis_clk),
    .areset          (areset),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_addr       (addr_r[0]),
    .req0_key        (key_r[0]),
    .req0_mask       (mask_r[0]),
    .req0_action     (act_r[0]),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_addr       (addr_r[1]),
    .req1_key        (key_r[1]),
    .req1_mask       (mask_r[1]),
    .req1_action     (act_r[1]),
    .cam_busy        (cam_busy),
    .lookup_din      (lookup_din),
    .lookup_din_mask (lookup_din_mask),
    .lookup_din_addr (lookup_din_addr),
    .lookup_din_en   (lookup_din_en),
    .action_data_in  (action_data_in),
    .action_addr     (action_addr),
    .action_en       (action_en),
    .cfg_done        (cfg_done),
    .cfg_done_id     (cfg_done_id),
    .cfg_err         (cfg_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters, sampled mid-cycle.
  int c_rdy = 0, c_en = 0, c_act = 0, c_done = 0;
  always @(negedge axis_clk) begin
    if (!areset) begin
      if (req0_ready) c_rdy++;
      if (req1_ready) c_rdy++;
      if (lookup_din_en) c_en++;
      if (action_en) c_act++;
      if (cfg_done) c_done++;
    end
  end

  // Reference model state.
  bit last    = 1'b1;   // requester served last
  bit err_exp = 1'b0;

  task automatic fill(input int n);
    for (int j = 0; j < KEY_W / 32; j++) begin
      key_r[n][j*32 +: 32]  = $urandom;
      mask_r[n][j*32 +: 32] = $urandom;
    end
    addr_r[n] = ADDR_W'($urandom);
    act_r[n]  = ACT_W'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_strobes"}, 64'({req0_ready, req1_ready, lookup_din_en, action_en,
                                     cfg_done, cfg_done_id, cfg_err}), 64'd0);
    check_eq({tag, "_data"}, 64'(|{lookup_din, lookup_din_mask, lookup_din_addr,
                                   action_data_in, action_addr}), 64'd0);
  endtask

  // One full transaction. r0/r1 raise that requester's valid (if not already pending), rnd
  // randomizes the payload of raised requesters, pre = busy cycles before the TCAM write,
  // b = busy-high cycles after the TCAM write (>= TMO means it never drops in time).
  task automatic do_txn(input bit r0, input bit r1, input bit rnd, input int pre, input int b);
    int   w, k, t_en, t_act, t_done, gap;
    int   s_rdy, s_en, s_act, s_done;
    logic got;
    @(posedge axis_clk); #1;
    if (r0 && !req0_valid) begin if (rnd) fill(0); req0_valid = 1'b1; end
    if (r1 && !req1_valid) begin if (rnd) fill(1); req1_valid = 1'b1; end
    w = (req0_valid && req1_valid) ? (last ? 0 : 1) : (req1_valid ? 1 : 0);
    s_rdy = c_rdy; s_en = c_en; s_act = c_act; s_done = c_done;
    got = 1'b0;
    k = 0;
    while (!got && k < 4) begin
      @(negedge axis_clk);
      if (req0_ready || req1_ready) got = 1'b1;
      else begin @(posedge axis_clk); #1; k++; end
    end
    check_eq("ready_seen", 64'(got), 64'd1);
    if (!got) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    check_eq("ready_lat", 64'(k), 64'd1);
    check_eq("ready_id", 64'(req1_ready), 64'(w));
    check_eq("ready_both", 64'(req0_ready && req1_ready), 64'd0);
    t_en = -1; t_act = -1; t_done = -1;
    for (int i = 1; i <= 60 && t_done < 0; i++) begin
      @(posedge axis_clk); #1;
      if (i == 1) begin
        if (w == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
      end
      if (t_en < 0) cam_busy = (i <= pre);
      else cam_busy = (t_act < 0) && (i - t_en <= b);
      @(negedge axis_clk);
      if (lookup_din_en && t_en < 0) begin
        t_en = i;
        for (int j = 0; j < KEY_W / 64; j++) begin
          check_eq($sformatf("key%0d", j), lookup_din[j*64 +: 64], key_r[w][j*64 +: 64]);
          check_eq($sformatf("mask%0d", j), lookup_din_mask[j*64 +: 64],
                   mask_r[w][j*64 +: 64]);
        end
        check_eq("cam_addr", 64'(lookup_din_addr), 64'(addr_r[w]));
      end
      if (action_en && t_act < 0) begin
        t_act = i;
        check_eq("act_addr", 64'(action_addr), 64'(addr_r[w]));
        check_eq("act_data", 64'(action_data_in), 64'(act_r[w]));
      end
      if (cfg_done) begin
        t_done = i;
        if (b >= int'(TMO)) err_exp = 1'b1;
        check_eq("done_id", 64'(cfg_done_id), 64'(w));
        check_eq("done_err", 64'(cfg_err), 64'(err_exp));
      end
    end
    cam_busy = 1'b0;
    #1;
    gap = (b >= 1 && b < int'(TMO)) ? b + 2 : int'(TMO) + 1;
    check_eq("t_en", 64'(t_en), 64'(pre + 1));
    check_eq("t_act", 64'(t_act), 64'(t_en + gap));
    check_eq("t_done", 64'(t_done), 64'(t_act + 1));
    check_eq("n_ready", 64'(c_rdy - s_rdy), 64'd1);
    check_eq("n_en", 64'(c_en - s_en), 64'd1);
    check_eq("n_act", 64'(c_act - s_act), 64'd1);
    check_eq("n_done", 64'(c_done - s_done), 64'd1);
    check_eq("hold_addr", 64'(action_addr), 64'(addr_r[w]));
    last = (w != 0);
  endtask

  // Reset asserted two cycles into the wait phase.
  task automatic reset_mid();
    int s_rdy, s_en, s_act, s_done;
    @(posedge axis_clk); #1;
    fill(0);
    req0_valid = 1'b1;
    s_rdy = c_rdy; s_en = c_en; s_act = c_act; s_done = c_done;
    @(posedge axis_clk); #1;
    @(posedge axis_clk); #1; req0_valid = 1'b0;
    @(posedge axis_clk); #1; cam_busy = 1'b1;
    @(posedge axis_clk); #1;
    @(posedge axis_clk); #1; areset = 1'b1;
    @(negedge axis_clk);
    check_all_zero("rst_mid");
    @(posedge axis_clk); #1; cam_busy = 1'b0;
    @(posedge axis_clk); #1; areset = 1'b0;
    repeat (5) @(posedge axis_clk);
    #1;
    check_eq("rst_n_ready", 64'(c_rdy - s_rdy), 64'd1);
    check_eq("rst_n_en", 64'(c_en - s_en), 64'd1);
    check_eq("rst_n_act", 64'(c_act - s_act), 64'd0);
    check_eq("rst_n_done", 64'(c_done - s_done), 64'd0);
    check_eq("rst_err_clr", 64'(cfg_err), 64'd0);
    last    = 1'b1;
    err_exp = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rdy, b, pre;
    bit r0, r1;
    for (int n = 0; n < 2; n++) begin
      key_r[n] = '0; mask_r[n] = '0; addr_r[n] = '0; act_r[n] = '0;
    end
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    check_all_zero("reset");
    @(posedge axis_clk); #1;
    areset = 1'b0;

    // Both requesters together: 0 first, then 1.
    do_txn(1'b1, 1'b1, 1'b1, 0, 1);
    do_txn(1'b0, 1'b0, 1'b1, 0, 1);

    // req0, addr 3, action 0x15, busy for 2 cycles.
    fill(0);
    addr_r[0] = 4'd3;
    act_r[0]  = 25'h15;
    do_txn(1'b1, 1'b0, 1'b0, 0, 2);

    // Busy on entry to the TCAM write for 5 cycles.
    do_txn(1'b1, 1'b0, 1'b1, 5, 1);

    // Busy stuck high: timeout sets the sticky error.
    do_txn(1'b0, 1'b1, 1'b1, 0, 20);
    do_txn(1'b1, 1'b0, 1'b1, 0, 0);

    // Reset mid-write, then normal service.
    reset_mid();
    do_txn(1'b1, 1'b0, 1'b1, 0, 1);

    // req1 valid dropped before arbitration: no accept.
    @(posedge axis_clk); #1;
    fill(1);
    req1_valid = 1'b1;
    s_rdy = c_rdy;
    @(posedge axis_clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge axis_clk);
    #1;
    check_eq("drop_ready", 64'(c_rdy - s_rdy), 64'd0);
    do_txn(1'b0, 1'b1, 1'b1, 0, 3);

    // Randomized traffic.
    repeat (20) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1 && !req0_valid && !req1_valid) r0 = 1'b1;
      pre = $urandom_range(0, 3);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 8);
      do_txn(r0, r1, 1'b1, pre, b);
    end
    while (req0_valid || req1_valid) do_txn(1'b0, 1'b0, 1'b1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
